// File: rtl/mlp_scorer.sv
// Scores MLPWrapper predictions against a synchronous label ROM; accuracy is computed by repeated subtraction after the last case.
// Latency: 3 enabled cycles per case, plus acr+1 for the divide. A ready rise seen while busy is dropped and sets sticky overrun.
module mlp_scorer #(
    parameter int size_of_output_layer       = 10,
    parameter int number_of_test_cases       = 750,
    parameter int clog2_size_of_output_layer = 4,
    parameter int clog2_number_of_test_cases = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clk_en,
    input  logic [clog2_size_of_output_layer-1:0] label,
    input  logic                                  ready,
    output logic [clog2_number_of_test_cases-1:0] exp_addr,
    input  logic [clog2_size_of_output_layer-1:0] exp_label,
    output logic                                  result_valid,
    output logic                                  mismatch,
    output logic [clog2_number_of_test_cases:0]   correct_count,
    output logic [clog2_number_of_test_cases:0]   wrong_count,
    output logic [clog2_number_of_test_cases:0]   case_count,
    output logic                                  overrun,
    output logic [6:0]                            acr,
    output logic                                  done
);
    localparam int L  = clog2_size_of_output_layer;
    localparam int LW = L + 1;
    localparam int CW = clog2_number_of_test_cases + 1;
    localparam logic [LW-1:0] NUM_CLASSES = LW'(size_of_output_layer);
    localparam logic [CW-1:0] N_CNT       = CW'(number_of_test_cases);
    localparam logic [16:0]   N_REM       = 17'(number_of_test_cases);

    typedef enum logic [2:0] {IDLE, FETCH, COMPARE, DIVIDE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ready_q;
    logic          rise;
    logic          wrong;
    logic          last;
    logic          busy;
    logic [L-1:0]  label_q;
    logic [CW-1:0] idx;
    logic [CW-1:0] correct_nxt;
    logic [16:0]   rem;
    logic [6:0]    q;

    assign rise        = ready & ~ready_q;
    assign wrong       = (label_q != exp_label) || ({1'b0, label_q} >= NUM_CLASSES);
    assign last        = (case_count + CW'(1)) == N_CNT;
    assign correct_nxt = correct_count + (wrong ? CW'(0) : CW'(1));
    assign busy        = (state == FETCH) || (state == COMPARE) || (state == DIVIDE);
    // idx is one bit wider than the address so it can rest at N after the last case
    assign exp_addr    = idx[CW-2:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = FETCH;
            FETCH:   state_nxt = COMPARE;
            COMPARE: state_nxt = last ? DIVIDE : IDLE;
            DIVIDE:  if (rem < N_REM) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ready_q       <= 1'b0;
            label_q       <= '0;
            idx           <= '0;
            correct_count <= '0;
            wrong_count   <= '0;
            case_count    <= '0;
            result_valid  <= 1'b0;
            mismatch      <= 1'b0;
            overrun       <= 1'b0;
            rem           <= '0;
            q             <= '0;
            acr           <= '0;
            done          <= 1'b0;
        end else if (clk_en) begin
            state        <= state_nxt;
            ready_q      <= ready;
            result_valid <= 1'b0;
            mismatch     <= 1'b0;
            if (rise && busy)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (rise)
                        label_q <= label;
                end
                COMPARE: begin
                    result_valid  <= 1'b1;
                    mismatch      <= wrong;
                    correct_count <= correct_nxt;
                    if (wrong)
                        wrong_count <= wrong_count + CW'(1);
                    case_count <= case_count + CW'(1);
                    if (idx < N_CNT)
                        idx <= idx + CW'(1);
                    // dividend must include the case being scored on this same edge
                    if (last) begin
                        rem <= 17'(correct_nxt) * 17'd100;
                        q   <= '0;
                    end
                end
                DIVIDE: begin
                    if (rem >= N_REM) begin
                        rem <= rem - N_REM;
                        q   <= q + 7'd1;
                    end else begin
                        acr  <= q;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_scorer.sv
// Directed bench for mlp_scorer: a small N=4 instance for the scenario tests and a default-parameter instance for the full run.
module tb_mlp_scorer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;

    logic [3:0]  label_a = '0;
    logic        ready_a = 1'b0;
    logic [2:0]  exp_addr_a;
    logic [3:0]  exp_label_a = '0;
    logic        result_valid_a, mismatch_a, overrun_a, done_a;
    logic [3:0]  correct_a, wrong_a, case_a;
    logic [6:0]  acr_a;

    logic [3:0]  label_f = '0;
    logic        ready_f = 1'b0;
    logic [9:0]  exp_addr_f;
    logic [3:0]  exp_label_f = '0;
    logic        result_valid_f, mismatch_f, overrun_f, done_f;
    logic [10:0] correct_f, wrong_f, case_f;
    logic [6:0]  acr_f;

    logic [3:0] rom_a [0:7];
    logic [3:0] rom_f [0:1023];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_label_a <= rom_a[exp_addr_a];
        exp_label_f <= rom_f[exp_addr_f];
    end

    mlp_scorer #(
        .size_of_output_layer(10), .number_of_test_cases(4),
        .clog2_size_of_output_layer(4), .clog2_number_of_test_cases(3)
    ) u_small (
        .clk(clk), .rst(rst), .clk_en(clk_en), .label(label_a), .ready(ready_a),
        .exp_addr(exp_addr_a), .exp_label(exp_label_a), .result_valid(result_valid_a),
        .mismatch(mismatch_a), .correct_count(correct_a), .wrong_count(wrong_a),
        .case_count(case_a), .overrun(overrun_a), .acr(acr_a), .done(done_a)
    );

    mlp_scorer u_full (
        .clk(clk), .rst(rst), .clk_en(clk_en), .label(label_f), .ready(ready_f),
        .exp_addr(exp_addr_f), .exp_label(exp_label_f), .result_valid(result_valid_f),
        .mismatch(mismatch_f), .correct_count(correct_f), .wrong_count(wrong_f),
        .case_count(case_f), .overrun(overrun_f), .acr(acr_f), .done(done_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_case_a(input logic [3:0] pred);
        label_a = pred;
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rom_a[0] = 4'd3; rom_a[1] = 4'd1; rom_a[2] = 4'd4; rom_a[3] = 4'd1;
        rst = 1'b1; ready_a = 1'b1; label_a = 4'd3;
        tick();
        tick();
        checks++;
        if ({result_valid_a, mismatch_a, overrun_a, done_a} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {result_valid_a, mismatch_a, overrun_a, done_a});
        end
        checks++;
        if ({correct_a, wrong_a, case_a, exp_addr_a} !== 15'd0) begin
            errors++; $display("FAIL reset_counts: got c=%0d w=%0d n=%0d a=%0d expected all 0", correct_a, wrong_a, case_a, exp_addr_a);
        end
        checks++;
        if (acr_a !== 7'd0) begin
            errors++; $display("FAIL reset_acr: got %0d expected 0", acr_a);
        end
        rst = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (result_valid_a !== 1'b1 || case_a !== 4'd1 || correct_a !== 4'd1 || mismatch_a !== 1'b0) begin
            errors++; $display("FAIL held_ready_first_case: got rv=%b n=%0d c=%0d m=%b expected rv=1 n=1 c=1 m=0", result_valid_a, case_a, correct_a, mismatch_a);
        end
        checks++;
        if (exp_addr_a !== 3'd1) begin
            errors++; $display("FAIL addr_advance: got %0d expected 1", exp_addr_a);
        end
        repeat (5) tick();
        checks++;
        if (case_a !== 4'd1 || result_valid_a !== 1'b0) begin
            errors++; $display("FAIL held_ready_single: got n=%0d rv=%b expected n=1 rv=0", case_a, result_valid_a);
        end
        ready_a = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] preds [4];
        logic       exp_m [4];
        preds = '{4'd3, 4'd2, 4'd4, 4'd1};
        exp_m = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_case_a(preds[k]);
            checks++;
            if (result_valid_a !== 1'b1 || mismatch_a !== exp_m[k]) begin
                errors++; $display("FAIL basic_case%0d: got rv=%b m=%b expected rv=1 m=%b", k, result_valid_a, mismatch_a, exp_m[k]);
            end
        end
        checks++;
        if (correct_a !== 4'd3 || wrong_a !== 4'd1 || case_a !== 4'd4) begin
            errors++; $display("FAIL basic_counts: got c=%0d w=%0d n=%0d expected 3 1 4", correct_a, wrong_a, case_a);
        end
        repeat (75) tick();
        checks++;
        if (done_a !== 1'b0) begin
            errors++; $display("FAIL divide_early: got done=%b expected 0 after 75 cycles", done_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b1 || acr_a !== 7'd75) begin
            errors++; $display("FAIL divide_result: got done=%b acr=%0d expected 1 75", done_a, acr_a);
        end
        ready_a = 1'b1; label_a = 4'd3;
        tick();
        ready_a = 1'b0;
        repeat (4) tick();
        checks++;
        if (done_a !== 1'b1 || acr_a !== 7'd75 || case_a !== 4'd4 || overrun_a !== 1'b0) begin
            errors++; $display("FAIL done_hold: got done=%b acr=%0d n=%0d ov=%b expected 1 75 4 0", done_a, acr_a, case_a, overrun_a);
        end
    endtask

    task automatic test_out_of_range();
        rom_a[0] = 4'd12;
        do_reset();
        drive_case_a(4'd12);
        checks++;
        if (mismatch_a !== 1'b1 || wrong_a !== 4'd1 || correct_a !== 4'd0) begin
            errors++; $display("FAIL out_of_range: got m=%b w=%0d c=%0d expected 1 1 0", mismatch_a, wrong_a, correct_a);
        end
        rom_a[0] = 4'd3;
    endtask

    task automatic test_overrun();
        do_reset();
        label_a = 4'd3;
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        tick();
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        checks++;
        if (overrun_a !== 1'b1 || case_a !== 4'd1 || result_valid_a !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got ov=%b n=%0d rv=%b expected 1 1 1", overrun_a, case_a, result_valid_a);
        end
        repeat (6) tick();
        checks++;
        if (overrun_a !== 1'b1 || case_a !== 4'd1) begin
            errors++; $display("FAIL overrun_sticky: got ov=%b n=%0d expected 1 1", overrun_a, case_a);
        end
        do_reset();
        checks++;
        if (overrun_a !== 1'b0) begin
            errors++; $display("FAIL overrun_clear: got %b expected 0", overrun_a);
        end
    endtask

    task automatic test_clk_en();
        rom_a[0] = 4'd1;
        do_reset();
        label_a = 4'd1;
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        clk_en = 1'b0;
        repeat (5) tick();
        clk_en = 1'b1;
        tick();
        checks++;
        if (result_valid_a !== 1'b0) begin
            errors++; $display("FAIL gate_delay: got rv=%b expected 0 one cycle after gating", result_valid_a);
        end
        tick();
        checks++;
        if (result_valid_a !== 1'b1 || case_a !== 4'd1 || correct_a !== 4'd1) begin
            errors++; $display("FAIL gate_complete: got rv=%b n=%0d c=%0d expected 1 1 1", result_valid_a, case_a, correct_a);
        end
        clk_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (result_valid_a !== 1'b1 || case_a !== 4'd1) begin
            errors++; $display("FAIL gate_stretch: got rv=%b n=%0d expected 1 1", result_valid_a, case_a);
        end
        clk_en = 1'b1;
        tick();
        checks++;
        if (result_valid_a !== 1'b0) begin
            errors++; $display("FAIL gate_release: got rv=%b expected 0", result_valid_a);
        end
        rom_a[0] = 4'd3;
    endtask

    task automatic test_reset_mid_divide();
        do_reset();
        drive_case_a(4'd3);
        drive_case_a(4'd1);
        drive_case_a(4'd4);
        drive_case_a(4'd1);
        repeat (10) tick();
        do_reset();
        checks++;
        if (done_a !== 1'b0 || case_a !== 4'd0 || correct_a !== 4'd0 || acr_a !== 7'd0) begin
            errors++; $display("FAIL mid_divide_reset: got done=%b n=%0d c=%0d acr=%0d expected 0 0 0 0", done_a, case_a, correct_a, acr_a);
        end
        repeat (120) tick();
        checks++;
        if (done_a !== 1'b0) begin
            errors++; $display("FAIL mid_divide_idle: got done=%b expected 0", done_a);
        end
    endtask

    task automatic test_full_run();
        int seen_wrong;
        int rv_bad;
        logic [3:0] r;
        logic bad;
        seen_wrong = 0;
        rv_bad = 0;
        for (int i = 0; i < 1024; i++) rom_f[i] = 4'(i % 10);
        do_reset();
        for (int i = 0; i < 750; i++) begin
            r = rom_f[i];
            bad = (i < 720) && (i % 12 == 0);
            label_f = bad ? ((r == 4'd9) ? 4'd0 : r + 4'd1) : r;
            ready_f = 1'b1;
            tick();
            ready_f = 1'b0;
            tick();
            tick();
            if (result_valid_f !== 1'b1) rv_bad++;
            if (mismatch_f === 1'b1) seen_wrong++;
        end
        checks++;
        if (rv_bad != 0 || seen_wrong != 60) begin
            errors++; $display("FAIL full_pulses: got missing_rv=%0d mismatches=%0d expected 0 60", rv_bad, seen_wrong);
        end
        checks++;
        if (correct_f !== 11'd690 || wrong_f !== 11'd60 || case_f !== 11'd750) begin
            errors++; $display("FAIL full_counts: got c=%0d w=%0d n=%0d expected 690 60 750", correct_f, wrong_f, case_f);
        end
        for (int k = 0; k < 200 && done_f !== 1'b1; k++) tick();
        checks++;
        if (done_f !== 1'b1 || acr_f !== 7'd92) begin
            errors++; $display("FAIL full_acr: got done=%b acr=%0d expected 1 92", done_f, acr_f);
        end
        repeat (3) begin
            ready_f = 1'b1;
            tick();
            ready_f = 1'b0;
            tick();
        end
        checks++;
        if (done_f !== 1'b1 || acr_f !== 7'd92 || case_f !== 11'd750 || overrun_f !== 1'b0 || correct_f !== 11'd690) begin
            errors++; $display("FAIL full_done_hold: got done=%b acr=%0d n=%0d ov=%b c=%0d expected 1 92 750 0 690", done_f, acr_f, case_f, overrun_f, correct_f);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rom_a[i] = 4'd0;
        for (int i = 0; i < 1024; i++) rom_f[i] = 4'd0;
        test_reset();
        test_basic();
        test_out_of_range();
        test_overrun();
        test_clk_en();
        test_reset_mid_divide();
        test_full_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
